y_channel_arbiter: RTL and testbench

Y_CHANNEL_ARBITER -- requirements
Module: y_channel_arbiter

---
 rtl/y_arb_pkg.sv | 16 +
 rtl/y_parity.sv | 11 +
 rtl/y_channel_arbiter.sv | 115 +++++++++++
 tb/tb_y_channel_arbiter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/y_arb_pkg.sv
// Shared types and constants for the two-source parity-checking channel arbiter.
package y_arb_pkg;

  localparam int DATA_W   = 32;
  localparam int ERRW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    YDROP = 2'd2,
    RACK  = 2'd3
  } arb_state_t;

  typedef logic src_t;

endpackage

// File: rtl/y_parity.sv
// Even-parity generator: reduction XOR over one data word.
module y_parity
  import y_arb_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output logic              parity
);

  assign parity = ^data;

endmodule

// File: rtl/y_channel_arbiter.sv
// Two-requester round-robin arbiter onto one downstream channel with 4-phase
// handshakes on both sides; parity-bad words are acknowledged upstream and dropped.
//
// state | meaning
// IDLE  | waiting for a request; grants at the next edge
// SEND  | YREQ high, waiting for YACK
// YDROP | downstream accepted, waiting for YACK to fall
// RACK  | ACK[YSRC] high, waiting for REQ[YSRC] to fall
module y_channel_arbiter
  import y_arb_pkg::*;
#(
  parameter int ERRW = ERRW_DEF
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              REQ0,
  input  logic [DATA_W-1:0] DATA0,
  input  logic              PAR0,
  output logic              ACK0,
  input  logic              REQ1,
  input  logic [DATA_W-1:0] DATA1,
  input  logic              PAR1,
  output logic              ACK1,
  output logic              YREQ,
  output logic [DATA_W-1:0] YDATA,
  output logic              YPARITY,
  input  logic              YACK,
  output logic              YSRC,
  output logic              BUSY,
  output logic [ERRW-1:0]   PERRCNT
);

  arb_state_t        state, state_nxt;
  src_t              prio;
  src_t              win;
  src_t              ysrc_q;
  logic [DATA_W-1:0] mux_data;
  logic              mux_par;
  logic              calc_par;
  logic              par_ok;
  logic              grant;
  logic              req_src;
  logic              release_src;

  // Lone requester wins; on contention the round-robin pointer decides.
  always_comb begin
    win = src_t'(REQ1);
    if (REQ0 && REQ1) win = prio;
  end

  assign mux_data = win ? DATA1 : DATA0;
  assign mux_par  = win ? PAR1 : PAR0;

  y_parity u_parity (
    .data   (mux_data),
    .parity (calc_par)
  );

  assign par_ok  = (mux_par == calc_par);
  assign req_src = ysrc_q ? REQ1 : REQ0;

  always_comb begin
    state_nxt   = state;
    grant       = 1'b0;
    release_src = 1'b0;
    case (state)
      IDLE: begin
        if (REQ0 || REQ1) begin
          grant     = 1'b1;
          state_nxt = par_ok ? SEND : RACK;
        end
      end
      SEND: begin
        if (YACK) state_nxt = YDROP;
      end
      YDROP: begin
        if (!YACK) state_nxt = RACK;
      end
      RACK: begin
        if (!req_src) begin
          release_src = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= IDLE;
      prio    <= 1'b0;
      ysrc_q  <= 1'b0;
      YDATA   <= '0;
      YPARITY <= 1'b0;
      PERRCNT <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        YDATA   <= mux_data;
        YPARITY <= mux_par;
        ysrc_q  <= win;
        if (!par_ok && (PERRCNT != '1)) PERRCNT <= PERRCNT + 1'b1;
      end
      if (release_src) prio <= ~ysrc_q;
    end
  end

  assign YREQ = (state == SEND);
  assign BUSY = (state != IDLE);
  assign YSRC = ysrc_q;
  assign ACK0 = (state == RACK) && !ysrc_q;
  assign ACK1 = (state == RACK) &&  ysrc_q;

endmodule

// File: tb/tb_y_channel_arbiter.sv
// Directed bench: per-cycle vector table plus hand sequences for stall, reset,
// held acknowledge and counter saturation.
module tb_y_channel_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        REQ0, PAR0, REQ1, PAR1, YACK;
  logic [31:0] DATA0, DATA1;
  logic        ACK0, ACK1, YREQ, YPARITY, YSRC, BUSY;
  logic [31:0] YDATA;
  logic [7:0]  PERRCNT;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  y_channel_arbiter #(.ERRW(8)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .REQ0(REQ0), .DATA0(DATA0), .PAR0(PAR0), .ACK0(ACK0),
    .REQ1(REQ1), .DATA1(DATA1), .PAR1(PAR1), .ACK1(ACK1),
    .YREQ(YREQ), .YDATA(YDATA), .YPARITY(YPARITY), .YACK(YACK),
    .YSRC(YSRC), .BUSY(BUSY), .PERRCNT(PERRCNT)
  );

  typedef struct {
    logic        rst, r0;
    logic [31:0] d0;
    logic        p0, r1;
    logic [31:0] d1;
    logic        p1, yk;
    logic        eyreq, ea0, ea1, ebusy, esrc;
    logic [31:0] edata;
    logic        epar;
    logic [7:0]  ecnt;
  } vec_t;

  localparam logic [31:0] A = 32'hA5A5_0001; // parity 1
  localparam logic [31:0] B = 32'h0000_0001; // parity 1, sent with PAR=0
  localparam logic [31:0] C = 32'h0000_0003; // parity 0
  localparam logic [31:0] D = 32'h0000_0007; // parity 1
  localparam logic [31:0] E = 32'hDEAD_BEEF; // parity 0

  vec_t vecs [25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic rst, input logic r0, input logic [31:0] d0, input logic p0,
                       input logic r1, input logic [31:0] d1, input logic p1, input logic yk);
    HRESET = rst; REQ0 = r0; DATA0 = d0; PAR0 = p0;
    REQ1 = r1; DATA1 = d1; PAR1 = p1; YACK = yk;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    //           rst r0 d0 p0 r1 d1 p1 yk | yreq a0 a1 busy src data par cnt
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 1, A, 1, 0, 0, 0, 0,   1, 0, 0, 1, 0, A, 1, 0};
    vecs[2]  = '{0, 1, A, 1, 0, 0, 0, 0,   1, 0, 0, 1, 0, A, 1, 0};
    vecs[3]  = '{0, 1, A, 1, 0, 0, 0, 1,   0, 0, 0, 1, 0, A, 1, 0};
    vecs[4]  = '{0, 1, A, 1, 0, 0, 0, 1,   0, 0, 0, 1, 0, A, 1, 0};
    vecs[5]  = '{0, 1, A, 1, 0, 0, 0, 0,   0, 1, 0, 1, 0, A, 1, 0};
    vecs[6]  = '{0, 1, A, 1, 0, 0, 0, 0,   0, 1, 0, 1, 0, A, 1, 0};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, A, 1, 0};
    vecs[8]  = '{0, 0, 0, 0, 1, B, 0, 0,   0, 0, 1, 1, 1, B, 0, 1};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, B, 0, 1};
    vecs[10] = '{0, 1, C, 0, 1, D, 1, 0,   1, 0, 0, 1, 0, C, 0, 1};
    vecs[11] = '{0, 1, C, 0, 1, D, 1, 1,   0, 0, 0, 1, 0, C, 0, 1};
    vecs[12] = '{0, 1, C, 0, 1, D, 1, 0,   0, 1, 0, 1, 0, C, 0, 1};
    vecs[13] = '{0, 0, 0, 0, 1, D, 1, 0,   0, 0, 0, 0, 0, C, 0, 1};
    vecs[14] = '{0, 1, C, 0, 1, D, 1, 0,   1, 0, 0, 1, 1, D, 1, 1};
    vecs[15] = '{0, 1, C, 0, 1, D, 1, 1,   0, 0, 0, 1, 1, D, 1, 1};
    vecs[16] = '{0, 1, C, 0, 1, D, 1, 0,   0, 0, 1, 1, 1, D, 1, 1};
    vecs[17] = '{0, 1, C, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, D, 1, 1};
    vecs[18] = '{0, 1, C, 0, 1, D, 1, 1,   1, 0, 0, 1, 0, C, 0, 1};
    vecs[19] = '{0, 1, C, 0, 1, D, 1, 1,   0, 0, 0, 1, 0, C, 0, 1};
    vecs[20] = '{0, 1, C, 0, 1, D, 1, 0,   0, 1, 0, 1, 0, C, 0, 1};
    vecs[21] = '{0, 1, C, 0, 1, D, 1, 1,   0, 1, 0, 1, 0, C, 0, 1};
    vecs[22] = '{0, 0, 0, 0, 1, D, 1, 1,   0, 0, 0, 0, 0, C, 0, 1};
    vecs[23] = '{0, 0, 0, 0, 1, D, 1, 0,   1, 0, 0, 1, 1, D, 1, 1};
    vecs[24] = '{1, 0, 0, 0, 1, D, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0};

    cyc();
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].r0, vecs[i].d0, vecs[i].p0,
            vecs[i].r1, vecs[i].d1, vecs[i].p1, vecs[i].yk);
      cyc();
      chk($sformatf("v%0d yreq", i), 32'(YREQ), 32'(vecs[i].eyreq));
      chk($sformatf("v%0d ack0", i), 32'(ACK0), 32'(vecs[i].ea0));
      chk($sformatf("v%0d ack1", i), 32'(ACK1), 32'(vecs[i].ea1));
      chk($sformatf("v%0d busy", i), 32'(BUSY), 32'(vecs[i].ebusy));
      chk($sformatf("v%0d ysrc", i), 32'(YSRC), 32'(vecs[i].esrc));
      chk($sformatf("v%0d ydata", i), YDATA, vecs[i].edata);
      chk($sformatf("v%0d ypar", i), 32'(YPARITY), 32'(vecs[i].epar));
      chk($sformatf("v%0d perrcnt", i), 32'(PERRCNT), 32'(vecs[i].ecnt));
    end

    // Stuck downstream: SEND held 50 cycles with REQ1 also pending.
    drive(0, 1, E, 0, 1, D, 1, 0);
    cyc();
    chk("stall grant src", 32'(YSRC), 32'd0);
    for (int i = 0; i < 50; i++) begin
      cyc();
      chk("stall yreq", 32'(YREQ), 32'd1);
      chk("stall ydata", YDATA, E);
      chk("stall acks", {30'd0, ACK1, ACK0}, 32'd0);
    end
    YACK = 1'b1; cyc();
    YACK = 1'b0; cyc();
    chk("stall ack0", 32'(ACK0), 32'd1);
    REQ0 = 1'b0; cyc();
    // Pointer now favours source 1 under contention.
    REQ0 = 1'b1; cyc();
    chk("pre-reset grant src", 32'(YSRC), 32'd1);
    chk("pre-reset yreq", 32'(YREQ), 32'd1);

    // Reset during SEND abandons the word and clears the pointer.
    HRESET = 1'b1; cyc();
    chk("rst yreq", 32'(YREQ), 32'd0);
    chk("rst busy", 32'(BUSY), 32'd0);
    chk("rst acks", {30'd0, ACK1, ACK0}, 32'd0);
    chk("rst ydata", YDATA, 32'd0);
    HRESET = 1'b0; cyc();
    chk("regrant src", 32'(YSRC), 32'd0);
    chk("regrant ydata", YDATA, E);
    chk("regrant yreq", 32'(YREQ), 32'd1);

    // Held acknowledge: REQ0 stays high for 5 cycles in RACK.
    YACK = 1'b1; cyc();
    YACK = 1'b0; cyc();
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("held ack0", 32'(ACK0), 32'd1);
      chk("held ack1", 32'(ACK1), 32'd0);
      chk("held yreq", 32'(YREQ), 32'd0);
      chk("held ysrc", 32'(YSRC), 32'd0);
    end
    REQ0 = 1'b0; cyc();
    chk("held release ack0", 32'(ACK0), 32'd0);
    chk("held release busy", 32'(BUSY), 32'd0);
    cyc();
    chk("held next src", 32'(YSRC), 32'd1);

    // Parity-error counter saturation: 256 dropped words, two cycles apart.
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    HRESET = 1'b0;
    for (int i = 1; i <= 256; i++) begin
      REQ1 = 1'b1; DATA1 = B; PAR1 = 1'b0;
      cyc();
      chk("drop ack1", 32'(ACK1), 32'd1);
      chk("drop yreq", 32'(YREQ), 32'd0);
      if (i == 1)   chk("drop cnt first", 32'(PERRCNT), 32'd1);
      if (i == 200) chk("drop cnt mid", 32'(PERRCNT), 32'd200);
      if (i == 255) chk("drop cnt 255", 32'(PERRCNT), 32'hFF);
      if (i == 256) chk("drop cnt sat", 32'(PERRCNT), 32'hFF);
      REQ1 = 1'b0;
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
